// File: rtl/traffic_phase_scheduler_if.sv
// -----------------------------------------------------------------------------
// traffic_phase_scheduler_if
// Bundles the request/preempt inputs and the lamp/status outputs of the
// intersection scheduler.
//   master : the environment (drives requests and preempts, observes lamps)
//   slave  : the scheduler (observes requests and preempts, drives lamps)
// Signals:
//   ped_ns_req, ped_ew_req : pedestrian requests (pulse or level)
//   emg_ns, emg_ew         : emergency preempt levels
//   ns_g/ns_y/ns_r         : NS lamps
//   ew_g/ew_y/ew_r         : EW lamps
//   walk_ns, walk_ew       : walk lamps
//   ped_ns_ack, ped_ew_ack : one-cycle grant pulses
//   tick_o                 : internal prescaler tick, one cycle wide
//   phase                  : current phase (NS_G=0 .. AR2=5)
// Handshake: there is no valid/ready pair. A request is accepted by being
// high during a rising clk edge; the matching ack pulses for one cycle when
// the walk is granted at the start of the matching green.
// -----------------------------------------------------------------------------
interface traffic_phase_scheduler_if;
  logic       ped_ns_req;
  logic       ped_ew_req;
  logic       emg_ns;
  logic       emg_ew;
  logic       ns_g;
  logic       ns_y;
  logic       ns_r;
  logic       ew_g;
  logic       ew_y;
  logic       ew_r;
  logic       walk_ns;
  logic       walk_ew;
  logic       ped_ns_ack;
  logic       ped_ew_ack;
  logic       tick_o;
  logic [2:0] phase;

  modport master (
    output ped_ns_req, ped_ew_req, emg_ns, emg_ew,
    input  ns_g, ns_y, ns_r, ew_g, ew_y, ew_r,
    input  walk_ns, walk_ew, ped_ns_ack, ped_ew_ack, tick_o, phase
  );

  modport slave (
    input  ped_ns_req, ped_ew_req, emg_ns, emg_ew,
    output ns_g, ns_y, ns_r, ew_g, ew_y, ew_r,
    output walk_ns, walk_ew, ped_ns_ack, ped_ew_ack, tick_o, phase
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// -----------------------------------------------------------------------------
// traffic_phase_scheduler
// Two-way intersection sequencer:
//   NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> NS_G ...
// A prescaler produces a one-cycle tick every TICK_DIV clocks; phases are
// timed in ticks. Pedestrian requests are latched and granted on entry to the
// matching green. Emergency preempts hold or cut a green (NS has priority).
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : traffic_phase_scheduler_if.slave (requests in, lamps/status out)
// The phase output doubles as the FSM state debug view.
// -----------------------------------------------------------------------------
module traffic_phase_scheduler #(
  parameter int TICK_DIV = 100,
  parameter int NS_GREEN = 5,
  parameter int EW_GREEN = 5,
  parameter int YELLOW   = 2,
  parameter int ALL_RED  = 1,
  parameter int WALK     = 3,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  traffic_phase_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR1  = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR2  = 3'd5
  } phase_t;

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] NSG_LAST   = CNT_W'(NS_GREEN - 1);
  localparam logic [CNT_W-1:0] EWG_LAST   = CNT_W'(EW_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] WALK_LEN   = CNT_W'(WALK);

  phase_t           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             pend_ns_q, pend_ns_d;
  logic             pend_ew_q, pend_ew_d;
  logic             wflag_ns_q, wflag_ns_d;
  logic             wflag_ew_q, wflag_ew_d;
  logic             ack_ns_q, ack_ns_d;
  logic             ack_ew_q, ack_ew_d;

  logic             tick;
  logic [CNT_W-1:0] last_cnt;
  logic             at_end;
  logic             advance;
  logic             hold;
  phase_t           next_phase;

  assign tick = (presc_q == PRESC_LAST);

  // Last timer value of the current phase.
  always_comb begin
    last_cnt = AR_LAST;
    case (state_q)
      NS_G:       last_cnt = NSG_LAST;
      NS_Y, EW_Y: last_cnt = YEL_LAST;
      EW_G:       last_cnt = EWG_LAST;
      default:    last_cnt = AR_LAST;
    endcase
  end

  assign at_end = (timer_q == last_cnt);

  always_comb begin
    next_phase = NS_G;
    case (state_q)
      NS_G:    next_phase = NS_Y;
      NS_Y:    next_phase = AR1;
      AR1:     next_phase = EW_G;
      EW_G:    next_phase = EW_Y;
      EW_Y:    next_phase = AR2;
      default: next_phase = NS_G;
    endcase
  end

  // Preemption only acts in greens. emg_ns outranks emg_ew: it holds NS_G
  // and cuts EW_G; emg_ew only matters when emg_ns is low.
  always_comb begin
    hold    = 1'b0;
    advance = 1'b0;
    case (state_q)
      NS_G: begin
        hold    = bus.emg_ns;
        advance = !bus.emg_ns && (bus.emg_ew || at_end);
      end
      EW_G: begin
        hold    = !bus.emg_ns && bus.emg_ew;
        advance = bus.emg_ns || (!bus.emg_ew && at_end);
      end
      default: advance = at_end;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    presc_d    = tick ? '0 : presc_q + 1'b1;
    // A new request always sets pending; the grant below clears it only
    // when no request is present in the same cycle.
    pend_ns_d  = pend_ns_q | bus.ped_ns_req;
    pend_ew_d  = pend_ew_q | bus.ped_ew_req;
    wflag_ns_d = wflag_ns_q;
    wflag_ew_d = wflag_ew_q;
    ack_ns_d   = 1'b0;
    ack_ew_d   = 1'b0;
    if (tick) begin
      if (advance) begin
        state_d = next_phase;
        timer_d = '0;
        if (state_q == NS_G) wflag_ns_d = 1'b0;
        if (state_q == EW_G) wflag_ew_d = 1'b0;
        if (next_phase == NS_G && (pend_ns_q || bus.ped_ns_req)) begin
          wflag_ns_d = 1'b1;
          ack_ns_d   = 1'b1;
          pend_ns_d  = bus.ped_ns_req;
        end
        if (next_phase == EW_G && (pend_ew_q || bus.ped_ew_req)) begin
          wflag_ew_d = 1'b1;
          ack_ew_d   = 1'b1;
          pend_ew_d  = bus.ped_ew_req;
        end
      end else if (hold) begin
        // Saturate at the last count so release exits on the next tick.
        if (!at_end) timer_d = timer_q + 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NS_G;
      presc_q    <= '0;
      timer_q    <= '0;
      pend_ns_q  <= 1'b0;
      pend_ew_q  <= 1'b0;
      wflag_ns_q <= 1'b0;
      wflag_ew_q <= 1'b0;
      ack_ns_q   <= 1'b0;
      ack_ew_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      timer_q    <= timer_d;
      pend_ns_q  <= pend_ns_d;
      pend_ew_q  <= pend_ew_d;
      wflag_ns_q <= wflag_ns_d;
      wflag_ew_q <= wflag_ew_d;
      ack_ns_q   <= ack_ns_d;
      ack_ew_q   <= ack_ew_d;
    end
  end

  // Moore lamp decode.
  assign bus.ns_g       = (state_q == NS_G);
  assign bus.ns_y       = (state_q == NS_Y);
  assign bus.ns_r       = (state_q != NS_G) && (state_q != NS_Y);
  assign bus.ew_g       = (state_q == EW_G);
  assign bus.ew_y       = (state_q == EW_Y);
  assign bus.ew_r       = (state_q != EW_G) && (state_q != EW_Y);
  assign bus.walk_ns    = (state_q == NS_G) && wflag_ns_q && (timer_q < WALK_LEN);
  assign bus.walk_ew    = (state_q == EW_G) && wflag_ew_q && (timer_q < WALK_LEN);
  assign bus.ped_ns_ack = ack_ns_q;
  assign bus.ped_ew_ack = ack_ew_q;
  assign bus.tick_o     = tick;
  assign bus.phase      = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;
  localparam int TD  = 4;
  localparam int NSG = 5;
  localparam int EWG = 5;
  localparam int YEL = 2;
  localparam int AR  = 1;
  localparam int WLK = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  traffic_phase_scheduler_if bus ();

  traffic_phase_scheduler #(
    .TICK_DIV(TD), .NS_GREEN(NSG), .EW_GREEN(EWG),
    .YELLOW(YEL), .ALL_RED(AR), .WALK(WLK), .CNT_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time is tracked as cycles since reset (ticks fall where the count mod
  // TD equals TD-1) and ticks elapsed inside the current phase.
  int m_cyc;
  int m_ph;
  int m_el;
  bit m_pend[2];
  bit m_walk[2];
  bit m_ack[2];
  int dur[6] = '{NSG, YEL, AR, EWG, YEL, AR};

  always @(posedge clk) begin
    bit tk, leave, grant;
    bit req[2];
    int gph;
    if (rst) begin
      m_cyc = 0; m_ph = 0; m_el = 0;
      for (int d = 0; d < 2; d++) begin
        m_pend[d] = 0; m_walk[d] = 0; m_ack[d] = 0;
      end
    end else begin
      tk = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      req[0] = bus.ped_ns_req;
      req[1] = bus.ped_ew_req;
      m_ack[0] = 0;
      m_ack[1] = 0;
      leave = 0;
      if (tk) begin
        if ((m_ph == 0 && bus.emg_ns) || (m_ph == 3 && bus.emg_ew && !bus.emg_ns)) begin
          m_el = (m_el + 1 > dur[m_ph] - 1) ? dur[m_ph] - 1 : m_el + 1;
        end else if ((m_ph == 0 && bus.emg_ew) || (m_ph == 3 && bus.emg_ns)) begin
          leave = 1;
        end else if (m_el + 1 >= dur[m_ph]) begin
          leave = 1;
        end else begin
          m_el++;
        end
      end
      if (leave) begin
        if (m_ph == 0) m_walk[0] = 0;
        if (m_ph == 3) m_walk[1] = 0;
        m_ph = (m_ph + 1) % 6;
        m_el = 0;
      end
      for (int d = 0; d < 2; d++) begin
        gph   = (d == 0) ? 0 : 3;
        grant = leave && (m_ph == gph) && (m_pend[d] || req[d]);
        if (grant) begin
          m_walk[d] = 1;
          m_ack[d]  = 1;
          m_pend[d] = req[d];
        end else begin
          m_pend[d] = m_pend[d] | req[d];
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("phase",   int'(bus.phase),   m_ph);
      check("tick_o",  int'(bus.tick_o),  int'((m_cyc % TD) == TD - 1));
      check("ns_g",    int'(bus.ns_g),    int'(m_ph == 0));
      check("ns_y",    int'(bus.ns_y),    int'(m_ph == 1));
      check("ns_r",    int'(bus.ns_r),    int'(m_ph >= 2));
      check("ew_g",    int'(bus.ew_g),    int'(m_ph == 3));
      check("ew_y",    int'(bus.ew_y),    int'(m_ph == 4));
      check("ew_r",    int'(bus.ew_r),    int'(m_ph <= 2 || m_ph == 5));
      check("walk_ns", int'(bus.walk_ns), int'(m_ph == 0 && m_walk[0] && m_el < WLK));
      check("walk_ew", int'(bus.walk_ew), int'(m_ph == 3 && m_walk[1] && m_el < WLK));
      check("ack_ns",  int'(bus.ped_ns_ack), int'(m_ack[0]));
      check("ack_ew",  int'(bus.ped_ew_ack), int'(m_ack[1]));
      check("ns_one_lamp", int'(bus.ns_g) + int'(bus.ns_y) + int'(bus.ns_r), 1);
      check("ew_one_lamp", int'(bus.ew_g) + int'(bus.ew_y) + int'(bus.ew_r), 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.ped_ns_req = 1'b0;
    bus.ped_ew_req = 1'b0;
    bus.emg_ns     = 1'b0;
    bus.emg_ew     = 1'b0;
  endtask

  // Directed timeline; c is cycles since reset release, acted on at negedge.
  task automatic directed_step(input int c);
    case (c)
      0: begin
        check("lit_rst_phase", int'(bus.phase), 0);
        check("lit_rst_ns_g",  int'(bus.ns_g), 1);
        check("lit_rst_ew_r",  int'(bus.ew_r), 1);
        check("lit_rst_tick",  int'(bus.tick_o), 0);
      end
      3:   check("lit_first_tick", int'(bus.tick_o), 1);
      10:  bus.ped_ew_req = 1'b1;
      11:  bus.ped_ew_req = 1'b0;
      19:  check("lit_nsg_end", int'(bus.phase), 0);
      20:  check("lit_nsy_start", int'(bus.phase), 1);
      28:  check("lit_ar1_start", int'(bus.phase), 2);
      32: begin
        check("lit_ewg_start", int'(bus.phase), 3);
        check("lit_ack_ew", int'(bus.ped_ew_ack), 1);
      end
      33:  check("lit_ack_ew_once", int'(bus.ped_ew_ack), 0);
      43:  check("lit_walk_ew_last", int'(bus.walk_ew), 1);
      44:  check("lit_walk_ew_off", int'(bus.walk_ew), 0);
      96:  check("lit_2nd_ewg_nowalk", int'(bus.walk_ew), 0);
      99:  bus.emg_ns = 1'b1;
      100: check("lit_emg_cut_ewy", int'(bus.phase), 4);
      108: check("lit_emg_ar2", int'(bus.phase), 5);
      112: check("lit_emg_nsg", int'(bus.phase), 0);
      141: begin
        check("lit_nsg_held", int'(bus.phase), 0);
        bus.emg_ns = 1'b0;
      end
      144: check("lit_release_nsy", int'(bus.phase), 1);
      150: bus.ped_ns_req = 1'b1;
      151: bus.ped_ns_req = 1'b0;
      159: begin bus.emg_ns = 1'b1; bus.emg_ew = 1'b1; end
      160: check("lit_both_emg_ewy", int'(bus.phase), 4);
      161: begin bus.emg_ns = 1'b0; bus.emg_ew = 1'b0; end
      171: bus.ped_ns_req = 1'b1;
      172: begin
        bus.ped_ns_req = 1'b0;
        check("lit_ack_ns", int'(bus.ped_ns_ack), 1);
        check("lit_walk_ns", int'(bus.walk_ns), 1);
      end
      236: check("lit_ack_ns_again", int'(bus.ped_ns_ack), 1);
      240: bus.ped_ew_req = 1'b1;
      241: bus.ped_ew_req = 1'b0;
      268: check("lit_ack_ew_b", int'(bus.ped_ew_ack), 1);
      272: begin
        check("lit_walk_before_rst", int'(bus.walk_ew), 1);
        rst = 1'b1;
      end
      default: ;
    endcase
  endtask

  // ---------------- main ----------------
  initial begin
    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    for (int c = 0; c <= 272; c++) begin
      directed_step(c);
      @(negedge clk);
    end

    // One reset edge has passed: this is the first post-reset cycle.
    check("lit_midrst_phase", int'(bus.phase), 0);
    check("lit_midrst_ns_g", int'(bus.ns_g), 1);
    check("lit_midrst_ew_r", int'(bus.ew_r), 1);
    check("lit_midrst_walk", int'(bus.walk_ew), 0);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("lit_midrst_tick", int'(bus.tick_o), int'(k == 3));
    end

    // Randomised run: sparse requests, long-lived preempts, rare resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      bus.ped_ns_req = ($urandom_range(0, 29) == 0);
      bus.ped_ew_req = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 59) == 0) bus.emg_ns = ~bus.emg_ns;
      if ($urandom_range(0, 59) == 0) bus.emg_ew = ~bus.emg_ew;
      rst = ($urandom_range(0, 1499) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    repeat (5) @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Sequences a two-way intersection: NS green/yellow, all-red, EW green/yellow, all-red, then repeat.
- Generates its own one-cycle timing tick from a clock prescaler.
- Latches pedestrian walk requests and grants them at the start of the matching green.
- Applies emergency-vehicle preemption. Drives the six lamp outputs plus walk lamps directly.

Parameters:
- TICK_DIV, 100, clk cycles per tick (>=2)
- NS_GREEN, 5, NS green duration in ticks (>=1)
- EW_GREEN, 5, EW green duration in ticks (>=1)
- YELLOW, 2, yellow duration in ticks (>=1), both directions
- ALL_RED, 1, all-red clearance in ticks (>=1)
- WALK, 3, walk lamp duration in ticks (1..min(NS_GREEN,EW_GREEN))
- CNT_W, 8, width of tick-count timer and prescaler

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ped_ns_req  in  1  pedestrian request, NS crossing; pulse or level
- ped_ew_req  in  1  pedestrian request, EW crossing
- emg_ns  in  1  emergency preempt, NS direction; level
- emg_ew  in  1  emergency preempt, EW direction; level
- ns_g, ns_y, ns_r  out  1 each  NS lamps
- ew_g, ew_y, ew_r  out  1 each  EW lamps
- walk_ns, walk_ew  out  1 each  walk lamps
- ped_ns_ack, ped_ew_ack  out  1 each  one-cycle grant pulse
- tick_o  out  1  internal tick, one cycle wide
- phase  out  3  state encoding: NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5

Behaviour:
- Reset (rst high at a clk edge):
  - prescaler=0, timer=0, state=NS_G.
  - pend_ns=pend_ew=0, walk flags=0.
  - Resulting outputs: ns_g=1, ew_r=1, all other lamps, walks, acks and tick_o=0.
  - Reset mid-operation aborts the current phase and any active walk with the same result.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick_o=1 for exactly the one cycle in which prescaler==TICK_DIV-1.
  - First tick is TICK_DIV cycles after reset deasserts.
- Lamps (Moore decode of the state register, at most one lamp lit per direction):
  - NS_G: ns_g, ew_r.
  - NS_Y: ns_y, ew_r.
  - AR1/AR2: ns_r, ew_r.
  - EW_G: ew_g, ns_r.
  - EW_Y: ew_y, ns_r.
- Timer and transitions:
  - State and timer change only on cycles where tick_o=1.
  - On a tick, if timer==DUR(state)-1: go to the next state in sequence NS_G→NS_Y→AR1→EW_G→EW_Y→AR2→NS_G and set timer=0. Otherwise timer+1.
  - DUR is NS_GREEN, YELLOW, ALL_RED, EW_GREEN, YELLOW, ALL_RED respectively.
- Preemption (evaluated on tick, green states only; emg_ns wins when both are asserted):
  - NS_G with emg_ns=1: timer saturates at NS_GREEN-1, no exit; NS_G is held.
  - NS_G with emg_ew=1 and emg_ns=0: go to NS_Y on this tick regardless of timer.
  - EW_G with emg_ns=1: go to EW_Y on this tick.
  - EW_G with emg_ew=1 and emg_ns=0: hold, timer saturates.
  - Yellow and all-red phases always run their full duration; preemption has no effect there.
  - Exit from a held green after emergency release is on the next tick.
- Pedestrian requests:
  - pend_x is set when ped_x_req=1. It is cleared only when a walk is granted.
  - Set and clear in the same cycle: set wins. The request stays pending for the next green.
  - Grant happens on the tick transitioning into X_G, when pend_x or ped_x_req is asserted in that cycle. Effects:
    - walk_flag_x is set;
    - pend_x is cleared;
    - ped_x_ack=1 for the first cycle of X_G only.
  - walk_x = (state==X_G) && walk_flag_x && (timer < WALK).
  - walk_flag_x clears on leaving X_G. A preempted green therefore cuts walk immediately.
  - Requests arriving during X_G are held until the following X_G entry; there is no mid-green grant.
  - No walk is granted for the NS_G entered at reset.

Test Plan:
- TICK_DIV=4, defaults, no requests, 200 cycles after reset → phase sequence 0,1,2,3,4,5,0 with dwell 20,8,4,20,8,4 cycles. Exactly one lamp per direction is lit every cycle. tick_o pulses every 4 cycles.
- ped_ew_req pulse at cycle 10 → ped_ew_ack pulses in the first EW_G cycle (cycle 32). walk_ew is high for 12 cycles, then low for the remaining 8 of EW_G. A second EW_G has no walk.
- emg_ns=1 held from cycle 35 (in EW_G) → EW_Y entered at the tick at cycle 36, then AR2 at 44, then NS_G at 48. NS_G is held while emg_ns=1. Releasing emg_ns → NS_Y on the next tick.
- emg_ns=emg_ew=1 during EW_G → NS priority; same response as the previous scenario.
- ped_ns_req=1 in the exact cycle pend_ns is granted and cleared → the new request stays pending and is granted at the next NS_G entry.
- rst pulsed mid EW_G with a walk active → next cycle phase=0, ns_g=1, ew_r=1, walk_ew=0, prescaler restarts (first tick 4 cycles after release).
